// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/flag controller: registered read/write addresses, occupancy and status flags.
// Optional sticky overflow/underflow flags are built only when FIFO_PTR_ERR_FLAG_EN is defined.
module fifo_ptr_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int AF_THRESH = 240
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] WP,
  output logic [ADDR_W-1:0] RP,
  output logic              wr_accept,
  output logic              rd_accept,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);

  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic            full_nxt, empty_nxt, almost_full_nxt;

  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  assign WP = wr_ptr[ADDR_W-1:0];
  assign RP = rd_ptr[ADDR_W-1:0];

  // Flags are derived from the next pointer/count values so they land on the same edge as count.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (wr_accept) wr_ptr_nxt = wr_ptr + ONE;
    if (rd_accept) rd_ptr_nxt = rd_ptr + ONE;
    case ({wr_accept, rd_accept})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
    full_nxt  = (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]) &&
                (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]);
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    almost_full_nxt = (count_nxt >= AF_LVL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      full        <= full_nxt;
      empty       <= empty_nxt;
      almost_full <= almost_full_nxt;
    end
  end

`ifdef FIFO_PTR_ERR_FLAG_EN
  // Setting wins over a clear sampled in the same cycle so no error event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr_en && full)  ovf_err <= 1'b1;
      else if (err_clr)   ovf_err <= 1'b0;
      if (rd_en && empty) udf_err <= 1'b1;
      else if (err_clr)   udf_err <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed, table-driven bench for fifo_ptr_ctrl at default parameters.
// Error-flag expectations follow FIFO_PTR_ERR_FLAG_EN when the bench is built with it.
module tb_fifo_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] WP, RP;
  logic       wr_accept, rd_accept, full, empty, almost_full;
  logic [8:0] count;
  logic       ovf_err, udf_err;

  int compared = 0;
  int mismatched = 0;

`ifdef FIFO_PTR_ERR_FLAG_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  fifo_ptr_ctrl #(.ADDR_W(8), .AF_THRESH(240)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
    .WP(WP), .RP(RP), .wr_accept(wr_accept), .rd_accept(rd_accept),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wr;
    logic rd;
    logic exp_wacc;
    logic exp_racc;
    int   exp_count;
    int   exp_wp;
    int   exp_rp;
    logic exp_empty;
    logic exp_full;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic c);
    @(negedge clk);
    wr_en = w; rd_en = r; err_clr = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    wr_en = 0; rd_en = 0; err_clr = 0;
    rst_n = 0;
    #2;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic fillAll();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1, 0, 0);
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 2, 0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 2, 1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 3, 2, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 3, 2, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 3, 3, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 3, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 4, 3, 1'b0, 1'b0};

    // Reset state
    #12;
    checkOutput("rst_wp", WP, 0);
    checkOutput("rst_rp", RP, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_af", almost_full, 0);
    checkOutput("rst_ovf", ovf_err, 0);
    checkOutput("rst_udf", udf_err, 0);
    @(negedge clk);
    rst_n = 1;

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, 0);
      checkOutput($sformatf("v%0d_wacc", i), wr_accept, vecs[i].exp_wacc);
      checkOutput($sformatf("v%0d_racc", i), rd_accept, vecs[i].exp_racc);
      tick();
      checkOutput($sformatf("v%0d_count", i), count, vecs[i].exp_count);
      checkOutput($sformatf("v%0d_wp", i), WP, vecs[i].exp_wp);
      checkOutput($sformatf("v%0d_rp", i), RP, vecs[i].exp_rp);
      checkOutput($sformatf("v%0d_empty", i), empty, vecs[i].exp_empty);
      checkOutput($sformatf("v%0d_full", i), full, vecs[i].exp_full);
    end
    checkOutput("tbl_udf", udf_err, ERR_ON);

    // Asynchronous reset mid-stream with count=5
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0);
      tick();
    end
    checkOutput("pre_rst_count", count, 5);
    checkOutput("pre_rst_wp", WP, 5);
    @(negedge clk);
    wr_en = 0;
    #2;
    rst_n = 0;
    #1;
    checkOutput("async_rst_wp", WP, 0);
    checkOutput("async_rst_rp", RP, 0);
    checkOutput("async_rst_count", count, 0);
    checkOutput("async_rst_empty", empty, 1);
    @(negedge clk);
    rst_n = 1;

    // Fill from reset, watching almost_full around the threshold
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1, 0, 0);
      if (i == 0) checkOutput("fill_wacc0", wr_accept, 1);
      tick();
      if (i + 1 == 239) begin
        checkOutput("fill_af_239", almost_full, 0);
        checkOutput("fill_count_239", count, 239);
      end
      if (i + 1 == 240) begin
        checkOutput("fill_af_240", almost_full, 1);
        checkOutput("fill_count_240", count, 240);
      end
      if (i + 1 == 255) checkOutput("fill_full_255", full, 0);
    end
    checkOutput("fill_wp", WP, 0);
    checkOutput("fill_count", count, 256);
    checkOutput("fill_full", full, 1);
    checkOutput("fill_empty", empty, 0);
    checkOutput("fill_ovf_before", ovf_err, 0);

    // Overflow attempt
    applyStimulus(1, 0, 0);
    checkOutput("ovf_wacc", wr_accept, 0);
    tick();
    checkOutput("ovf_wp", WP, 0);
    checkOutput("ovf_count", count, 256);
    checkOutput("ovf_flag", ovf_err, ERR_ON);

    // Drain; sticky overflow must persist
    for (int i = 0; i < 256; i++) begin
      applyStimulus(0, 1, 0);
      if (i == 0) checkOutput("drain_racc0", rd_accept, 1);
      tick();
      if (i + 1 == 17) checkOutput("drain_af_239", almost_full, 0);
    end
    checkOutput("drain_rp", RP, 0);
    checkOutput("drain_empty", empty, 1);
    checkOutput("drain_count", count, 0);
    checkOutput("drain_ovf_sticky", ovf_err, ERR_ON);

    // Underflow attempt, then read at empty together with clear (set wins)
    applyStimulus(0, 1, 0);
    checkOutput("udf_racc", rd_accept, 0);
    tick();
    checkOutput("udf_rp", RP, 0);
    checkOutput("udf_flag", udf_err, ERR_ON);
    applyStimulus(0, 1, 1);
    tick();
    checkOutput("udf_set_prio", udf_err, ERR_ON);
    checkOutput("ovf_cleared", ovf_err, 0);
    applyStimulus(0, 0, 1);
    tick();
    checkOutput("udf_cleared", udf_err, 0);
    applyStimulus(0, 0, 0);
    tick();
    checkOutput("ovf_stays_clear", ovf_err, 0);

    // Full with both requests: only the read is taken
    doReset();
    fillAll();
    applyStimulus(1, 1, 0);
    checkOutput("fullboth_wacc", wr_accept, 0);
    checkOutput("fullboth_racc", rd_accept, 1);
    tick();
    checkOutput("fullboth_count", count, 255);
    checkOutput("fullboth_full", full, 0);
    checkOutput("fullboth_wp", WP, 0);
    checkOutput("fullboth_rp", RP, 1);

    // Simultaneous access at count=10 for 300 cycles
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0);
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 1, 0);
      tick();
    end
    applyStimulus(0, 0, 0);
    checkOutput("sim_count", count, 10);
    checkOutput("sim_wp", WP, 54);
    checkOutput("sim_rp", RP, 44);
    checkOutput("sim_diff", int'(WP - RP), 10);
    checkOutput("sim_full", full, 0);
    checkOutput("sim_empty", empty, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_ptr_ctrl.md
FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning pointer width; FIFO depth is 2**ADDR_W entries.
REQ-002 SHALL have parameter AF_THRESH, default 240, meaning occupancy at or above which almost_full asserts.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en, input, 1, meaning write request.
REQ-006 SHALL have port rd_en, input, 1, meaning read request.
REQ-007 SHALL have port WP, output, ADDR_W, meaning current write address into the storage RAM.
REQ-008 SHALL have port RP, output, ADDR_W, meaning current read address into the storage RAM.
REQ-009 SHALL have port wr_accept, output, 1, meaning combinational wr_en AND NOT full.
REQ-010 SHALL have port rd_accept, output, 1, meaning combinational rd_en AND NOT empty.
REQ-011 SHALL have port full, output, 1, meaning occupancy equals 2**ADDR_W.
REQ-012 SHALL have port empty, output, 1, meaning occupancy equals 0.
REQ-013 SHALL have port almost_full, output, 1, meaning count >= AF_THRESH.
REQ-014 SHALL have port count, output, ADDR_W+1, meaning current occupancy.
REQ-015 SHALL have ports ovf_err and udf_err, output, 1 each, and err_clr, input, 1, meaning sticky error flags and their clear (see Configuration).

Function
REQ-016 SHALL hold WP, RP, count and all flags in registers; outputs reflect the state after the last rising edge, with no combinational path from wr_en/rd_en except wr_accept/rd_accept.
REQ-017 SHALL increment WP by 1 modulo 2**ADDR_W on each edge with wr_accept=1; WP=255 wraps to 0 at the default width.
REQ-018 SHALL increment RP by 1 modulo 2**ADDR_W on each edge with rd_accept=1, with the same wrap rule.
REQ-019 SHALL keep internal ADDR_W+1-bit pointers whose MSB toggles on wrap; full = addresses equal and MSBs differ; empty = full internal pointers equal.
REQ-020 SHALL update count by +1 for an accepted write only, by -1 for an accepted read only, and hold it when both or neither are accepted.
REQ-021 SHALL, when empty and both wr_en and rd_en are high, accept only the write (rd_accept=0); next cycle count=1 and empty=0.
REQ-022 SHALL, when full and both are high, accept only the read (wr_accept=0); next cycle count=2**ADDR_W-1 and full=0.
REQ-023 SHALL update full, empty and almost_full on the same edge as count, always consistent with it.
REQ-024 SHALL never allow count outside 0..2**ADDR_W, and never assert full and empty together.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force WP=0, RP=0, count=0, empty=1, full=0, almost_full=0, ovf_err=0, udf_err=0.
REQ-026 SHALL hold that state while rst_n is low and resume on the first rising clk after release; a reset mid-operation discards all occupancy.

Configuration
REQ-027 SHALL, with macro FIFO_PTR_ERR_FLAG_EN defined, set ovf_err on any edge with wr_en=1 and full=1, set udf_err on any edge with rd_en=1 and empty=1, keep both set until err_clr=1 is sampled, and give set priority over clear in the same cycle.
REQ-028 SHALL, without FIFO_PTR_ERR_FLAG_EN, keep ovf_err and udf_err tied to 0, ignore err_clr, and instantiate no error registers.

Verification
REQ-029 SHALL cover reset: rst_n low mid-stream with count=5 -> WP=0, RP=0, count=0, empty=1 immediately, without waiting for a clock edge.
REQ-030 SHALL cover fill: 256 writes from reset -> WP=0 after wrap, count=256, full=1, almost_full asserted on the edge where count reaches 240; the 257th wr_en gives wr_accept=0 and WP stays unchanged.
REQ-031 SHALL cover drain: 256 reads after fill -> RP=0, empty=1; the next rd_en gives rd_accept=0 and RP stays unchanged.
REQ-032 SHALL cover simultaneous access: count=10 with wr_en=rd_en=1 for 300 cycles -> count stays 10 and WP and RP both wrap with WP-RP=10 mod 256.
REQ-033 SHALL cover boundaries: at empty, both requests -> count=1; at full, both requests -> count=255.
REQ-034 SHALL cover errors with FIFO_PTR_ERR_FLAG_EN defined: a write at full -> ovf_err=1 that persists until err_clr; a read at empty -> udf_err=1; without the macro both stay 0.
